// File: rtl/register_ram_dp.sv
// Dual-read, byte-enabled register file with a post-reset clearing sweep.
// Define REGISTER_RAM_BYPASS_EN to forward same-cycle writes to the read ports.
module register_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    ready,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]   data_input,
  input  logic [ADDR_WIDTH-1:0]   read_address_a,
  input  logic [ADDR_WIDTH-1:0]   read_address_b,
  output logic [DATA_WIDTH-1:0]   data_output_a,
  output logic [DATA_WIDTH-1:0]   data_output_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_clr_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_run;
  logic                    w_wr_en;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [NB-1:0]           w_wr_be;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [DATA_WIDTH-1:0]   w_rd_a;
  logic [DATA_WIDTH-1:0]   w_rd_b;

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_CLEAR && r_clr_ptr == ADDR_WIDTH'(DEPTH - 1))
      w_next = S_RUN;
  end

  // The sweep owns the write port while clearing
  always_comb begin
    ready     = (r_state == S_RUN);
    w_run     = (r_state == S_RUN);
    w_wr_en   = 1'b1;
    w_wr_addr = r_clr_ptr;
    w_wr_be   = '1;
    w_wr_data = '0;
    if (r_state == S_RUN) begin
      w_wr_en   = write_enable;
      w_wr_addr = write_address;
      w_wr_be   = byte_enable;
      w_wr_data = data_input;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      r_clr_ptr <= '0;
    else if (r_state == S_CLEAR)
      r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset_n && w_wr_en) begin
      for (int i = 0; i < NB; i++)
        if (w_wr_be[i])
          r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
    end
  end

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  always_comb begin
    w_rd_a = r_mem[read_address_a];
    w_rd_b = r_mem[read_address_b];
`ifdef REGISTER_RAM_BYPASS_EN
    if (write_enable && read_address_a == write_address)
      w_rd_a = merge(w_rd_a, data_input, byte_enable);
    if (write_enable && read_address_b == write_address)
      w_rd_b = merge(w_rd_b, data_input, byte_enable);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !w_run) begin
      data_output_a <= '0;
      data_output_b <= '0;
    end else begin
      data_output_a <= w_rd_a;
      data_output_b <= w_rd_b;
    end
  end

`ifndef REGISTER_RAM_BYPASS_EN
  logic [DATA_WIDTH-1:0] w_unused_merge;
  assign w_unused_merge = merge('0, '0, '0);
`endif

endmodule

// File: tb/tb_register_ram_dp.sv
// Scoreboard bench for register_ram_dp: stimulus queues expectations,
// a monitor compares them one cycle later.
module tb_register_ram_dp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        write_enable;
  logic [2:0]  write_address;
  logic [3:0]  byte_enable;
  logic [31:0] data_input;
  logic [2:0]  read_address_a;
  logic [2:0]  read_address_b;
  logic [31:0] data_output_a;
  logic [31:0] data_output_b;

  register_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ready          (ready),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .byte_enable    (byte_enable),
    .data_input     (data_input),
    .read_address_a (read_address_a),
    .read_address_b (read_address_b),
    .data_output_a  (data_output_a),
    .data_output_b  (data_output_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        er;
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic rd_valid = 1'b0;
  logic mon_v = 1'b0;

  always @(posedge clock) mon_v <= rd_valid;

  always @(negedge clock) begin
    if (mon_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: output with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (ready !== e.er) begin
          errors++;
          $display("FAIL %s ready: got %b want %b", e.nm, ready, e.er);
        end
        checks++;
        if (data_output_a !== e.ea) begin
          errors++;
          $display("FAIL %s A: got %h want %h", e.nm, data_output_a, e.ea);
        end
        checks++;
        if (data_output_b !== e.eb) begin
          errors++;
          $display("FAIL %s B: got %h want %h", e.nm, data_output_b, e.eb);
        end
      end
    end
  end

  task automatic cyc(
    input logic        rn,
    input logic        we,
    input logic [2:0]  wa,
    input logic [3:0]  be,
    input logic [31:0] din,
    input logic [2:0]  ra,
    input logic [2:0]  rb,
    input logic        chk,
    input logic        er,
    input logic [31:0] ea,
    input logic [31:0] eb,
    input string       nm
  );
    exp_t e;
    @(negedge clock);
    reset_n        = rn;
    write_enable   = we;
    write_address  = wa;
    byte_enable    = be;
    data_input     = din;
    read_address_a = ra;
    read_address_b = rb;
    rd_valid       = chk;
    if (chk) begin
      e.nm = nm; e.er = er; e.ea = ea; e.eb = eb;
      exp_q.push_back(e);
    end
    @(posedge clock);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    cyc(1, 1, a, be, d, 0, 0, 0, 0, 0, 0, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b,
                    input logic [31:0] ea, input logic [31:0] eb,
                    input string nm);
    cyc(1, 0, 0, 0, 0, a, b, 1, 1, ea, eb, nm);
  endtask

  logic [31:0] coll_exp;

  initial begin
    reset_n = 0; write_enable = 0; write_address = 0;
    byte_enable = 0; data_input = 0;
    read_address_a = 0; read_address_b = 0;
`ifdef REGISTER_RAM_BYPASS_EN
    coll_exp = 32'h0000FFFF;
`else
    coll_exp = 32'h00000000;
`endif

    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "reset0");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "reset1");
    for (int i = 0; i < 8; i++) begin
      if (i == 2)
        cyc(1, 1, 7, 4'hF, 32'h5A5A5A5A, 7, 7, 1, 0, 0, 0, "sweep_wr");
      else
        cyc(1, 0, 0, 0, 0, 0, 0, 1, (i == 7), 0, 0, "sweep");
    end
    for (int i = 0; i < 8; i++)
      rd(3'(i), 3'(7 - i), 0, 0, "cleared");

    wr(3, 4'hF, 32'hAABBCCDD);
    wr(3, 4'h5, 32'h11223344);
    rd(3, 3, 32'hAA22CC44, 32'hAA22CC44, "byte_en");
    cyc(1, 1, 3, 4'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, "wr");
    rd(3, 0, 32'hAA22CC44, 0, "be_zero");

    wr(1, 4'hF, 32'h12345678);
    wr(6, 4'hF, 32'hCAFEF00D);
    rd(1, 6, 32'h12345678, 32'hCAFEF00D, "dual");
    rd(6, 6, 32'hCAFEF00D, 32'hCAFEF00D, "same_addr");

    cyc(1, 1, 2, 4'h3, 32'hFFFFFFFF, 2, 3, 1, 1,
        coll_exp, 32'hAA22CC44, "collision");
    rd(2, 2, 32'h0000FFFF, 32'h0000FFFF, "after_coll");

    for (int i = 0; i < 8; i++)
      wr(3'(i), 4'hF, 32'h01010101 * (i + 1));
    rd(7, 0, 32'h08080808, 32'h01010101, "filled");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "mid_reset");
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 0, 0, 0, 5, 5, 1, (i == 7), 0, 0, "resweep");
    for (int i = 0; i < 8; i++)
      rd(3'(i), 3'(i), 0, 0, "recleared");

    @(negedge clock);
    rd_valid = 0;
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
